// File: rtl/etapa_wb_regfile.sv
// Write-back stage: load filtering, write-back select, 32-entry GPR file with
// write-through read bypass, debug read port and commit counter.
module etapa_wb_regfile #(
  parameter int unsigned NBITS  = 32,
  parameter int unsigned RNBITS = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NBITS-1:0]  i_PC8,
  input  logic [NBITS-1:0]  i_ALU,
  input  logic [NBITS-1:0]  i_DatoMemoria,
  input  logic [NBITS-1:0]  i_Extension,
  input  logic [RNBITS-1:0] i_RegistroDestino,
  input  logic              i_MemToReg,
  input  logic              i_RegWrite,
  input  logic [1:0]        i_TamanoFiltroL,
  input  logic              i_ZeroExtend,
  input  logic              i_LUI,
  input  logic              i_JAL,
  input  logic [RNBITS-1:0] i_RegLectura1,
  input  logic [RNBITS-1:0] i_RegLectura2,
  input  logic [RNBITS-1:0] i_RegDebug,
  output logic [NBITS-1:0]  o_DatoEscritura,
  output logic [NBITS-1:0]  o_DatoLeido1,
  output logic [NBITS-1:0]  o_DatoLeido2,
  output logic [NBITS-1:0]  o_DatoDebug,
  output logic [NBITS-1:0]  o_ContadorWB
);

  localparam int unsigned NumRegs = 2 ** RNBITS;

  logic [NBITS-1:0] gpr_q [NumRegs];
  logic [NBITS-1:0] cnt_q;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [NBITS-1:0] load_data;
  logic             wr_en;
  logic             unused_ext;

  // Only the low half of the immediate feeds LUI.
  assign unused_ext = ^i_Extension[NBITS-1:16];

  always_comb begin
    byte_sel = 8'h00;
    unique case (i_ALU[1:0])
      2'd0: byte_sel = i_DatoMemoria[7:0];
      2'd1: byte_sel = i_DatoMemoria[15:8];
      2'd2: byte_sel = i_DatoMemoria[23:16];
      2'd3: byte_sel = i_DatoMemoria[31:24];
      default: byte_sel = 8'h00;
    endcase
  end

  assign half_sel = i_ALU[1] ? i_DatoMemoria[31:16] : i_DatoMemoria[15:0];

  always_comb begin
    load_data = i_DatoMemoria;
    case (i_TamanoFiltroL)
      2'b00: load_data = {{(NBITS-8){byte_sel[7] & ~i_ZeroExtend}}, byte_sel};
      2'b01: load_data = {{(NBITS-16){half_sel[15] & ~i_ZeroExtend}}, half_sel};
      default: load_data = i_DatoMemoria;
    endcase
  end

  always_comb begin
    if (i_JAL) begin
      o_DatoEscritura = i_PC8;
    end else if (i_LUI) begin
      o_DatoEscritura = {i_Extension[15:0], {(NBITS-16){1'b0}}};
    end else if (i_MemToReg) begin
      o_DatoEscritura = load_data;
    end else begin
      o_DatoEscritura = i_ALU;
    end
  end

  assign wr_en = i_RegWrite && (i_RegistroDestino != '0);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        gpr_q[i] <= '0;
      end
      cnt_q <= '0;
    end else if (wr_en) begin
      gpr_q[i_RegistroDestino] <= o_DatoEscritura;
      cnt_q                    <= cnt_q + 1'b1;
    end
  end

  // Write-through: a read of the register being committed this edge sees the new value.
  always_comb begin
    if (i_RegLectura1 == '0) begin
      o_DatoLeido1 = '0;
    end else if (wr_en && (i_RegLectura1 == i_RegistroDestino)) begin
      o_DatoLeido1 = o_DatoEscritura;
    end else begin
      o_DatoLeido1 = gpr_q[i_RegLectura1];
    end
  end

  always_comb begin
    if (i_RegLectura2 == '0) begin
      o_DatoLeido2 = '0;
    end else if (wr_en && (i_RegLectura2 == i_RegistroDestino)) begin
      o_DatoLeido2 = o_DatoEscritura;
    end else begin
      o_DatoLeido2 = gpr_q[i_RegLectura2];
    end
  end

  always_comb begin
    if (i_RegDebug == '0) begin
      o_DatoDebug = '0;
    end else if (wr_en && (i_RegDebug == i_RegistroDestino)) begin
      o_DatoDebug = o_DatoEscritura;
    end else begin
      o_DatoDebug = gpr_q[i_RegDebug];
    end
  end

  assign o_ContadorWB = cnt_q;

endmodule

// File: tb/tb_etapa_wb_regfile.sv
// Bench for etapa_wb_regfile: directed vector table, corner sequences and
// randomized traffic against an array-based reference model.
module tb_etapa_wb_regfile;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_PC8, i_ALU, i_DatoMemoria, i_Extension;
  logic [4:0]  i_RegistroDestino, i_RegLectura1, i_RegLectura2, i_RegDebug;
  logic        i_MemToReg, i_RegWrite, i_ZeroExtend, i_LUI, i_JAL;
  logic [1:0]  i_TamanoFiltroL;
  logic [31:0] o_DatoEscritura, o_DatoLeido1, o_DatoLeido2, o_DatoDebug, o_ContadorWB;

  always #5 i_clk = ~i_clk;

  etapa_wb_regfile #(.NBITS(32), .RNBITS(5)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_PC8(i_PC8), .i_ALU(i_ALU),
    .i_DatoMemoria(i_DatoMemoria), .i_Extension(i_Extension),
    .i_RegistroDestino(i_RegistroDestino), .i_MemToReg(i_MemToReg),
    .i_RegWrite(i_RegWrite), .i_TamanoFiltroL(i_TamanoFiltroL),
    .i_ZeroExtend(i_ZeroExtend), .i_LUI(i_LUI), .i_JAL(i_JAL),
    .i_RegLectura1(i_RegLectura1), .i_RegLectura2(i_RegLectura2),
    .i_RegDebug(i_RegDebug), .o_DatoEscritura(o_DatoEscritura),
    .o_DatoLeido1(o_DatoLeido1), .o_DatoLeido2(o_DatoLeido2),
    .o_DatoDebug(o_DatoDebug), .o_ContadorWB(o_ContadorWB)
  );

  typedef struct {
    logic [31:0] pc8, alu, dato, ext;
    logic        mtr, lui, jal, zext;
    logic [1:0]  size;
    logic [4:0]  dest;
    logic [31:0] exp;
  } vec_t;

  logic [31:0] m_gpr [32];
  logic [31:0] m_cnt;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_wb();
    logic [31:0] raw;
    if (i_JAL) return i_PC8;
    if (i_LUI) return i_Extension << 16;
    if (!i_MemToReg) return i_ALU;
    if (i_TamanoFiltroL == 2'b00) begin
      raw = (i_DatoMemoria >> (8 * int'(i_ALU[1:0]))) & 32'hFF;
      if (!i_ZeroExtend && raw >= 32'h80) raw = raw | 32'hFFFF_FF00;
      return raw;
    end
    if (i_TamanoFiltroL == 2'b01) begin
      raw = (i_DatoMemoria >> (16 * int'(i_ALU[1]))) & 32'hFFFF;
      if (!i_ZeroExtend && raw >= 32'h8000) raw = raw | 32'hFFFF_0000;
      return raw;
    end
    return i_DatoMemoria;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (i_RegWrite && i_RegistroDestino != 0 && idx == i_RegistroDestino) return m_wb();
    return m_gpr[idx];
  endfunction

  // Advance one clock edge, updating the model with what that edge commits.
  task automatic tick();
    logic [31:0] wb;
    wb = m_wb();
    @(posedge i_clk);
    if (!i_reset) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
      m_cnt = 32'h0;
    end else if (i_RegWrite && i_RegistroDestino != 0) begin
      m_gpr[i_RegistroDestino] = wb;
      m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic idle();
    i_RegWrite = 0; i_JAL = 0; i_LUI = 0; i_MemToReg = 0; i_ZeroExtend = 0;
    i_TamanoFiltroL = 2'b11; i_PC8 = 0; i_ALU = 0; i_DatoMemoria = 0; i_Extension = 0;
    i_RegistroDestino = 0; i_RegLectura1 = 0; i_RegLectura2 = 0; i_RegDebug = 0;
  endtask

  task automatic do_reset();
    i_reset = 0;
    tick();
    i_reset = 1;
  endtask

  vec_t vecs [12];

  initial begin
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
    m_cnt = 0;
    idle();
    i_reset = 0;
    tick();
    tick();
    i_reset = 1;
    chk("reset_cnt", o_ContadorWB, 32'h0);
    i_RegDebug = 5'd17; #1;
    chk("reset_gpr17", o_DatoDebug, 32'h0);

    vecs[0]  = '{0, 32'h3, 32'h80F1_7F02, 0, 1, 0, 0, 0, 2'b00, 5'd1,  32'hFFFF_FF80};
    vecs[1]  = '{0, 32'h3, 32'h80F1_7F02, 0, 1, 0, 0, 1, 2'b00, 5'd2,  32'h0000_0080};
    vecs[2]  = '{0, 32'h1, 32'h80F1_7F02, 0, 1, 0, 0, 0, 2'b00, 5'd3,  32'h0000_007F};
    vecs[3]  = '{0, 32'h6, 32'h80F1_7F02, 0, 1, 0, 0, 0, 2'b00, 5'd4,  32'hFFFF_FFF1};
    vecs[4]  = '{0, 32'h2, 32'h8001_1234, 0, 1, 0, 0, 0, 2'b01, 5'd5,  32'hFFFF_8001};
    vecs[5]  = '{0, 32'h0, 32'h8001_1234, 0, 1, 0, 0, 0, 2'b01, 5'd6,  32'h0000_1234};
    vecs[6]  = '{0, 32'h1, 32'h8001_1234, 0, 1, 0, 0, 0, 2'b01, 5'd8,  32'h0000_1234};
    vecs[7]  = '{0, 32'h3, 32'h8001_1234, 0, 1, 0, 0, 1, 2'b01, 5'd9,  32'h0000_8001};
    vecs[8]  = '{0, 32'h1, 32'h80F1_7F02, 0, 1, 0, 0, 0, 2'b10, 5'd10, 32'h80F1_7F02};
    vecs[9]  = '{32'h40, 32'h77, 32'h99, 32'h1234, 1, 1, 1, 0, 2'b00, 5'd31, 32'h0000_0040};
    vecs[10] = '{0, 32'h77, 32'h99, 32'hFFFF_ABCD, 0, 1, 0, 0, 2'b00, 5'd11, 32'hABCD_0000};
    vecs[11] = '{0, 32'h1234_5678, 32'h99, 0, 0, 0, 0, 0, 2'b00, 5'd12, 32'h1234_5678};

    foreach (vecs[i]) begin
      i_PC8 = vecs[i].pc8; i_ALU = vecs[i].alu; i_DatoMemoria = vecs[i].dato;
      i_Extension = vecs[i].ext; i_MemToReg = vecs[i].mtr; i_LUI = vecs[i].lui;
      i_JAL = vecs[i].jal; i_ZeroExtend = vecs[i].zext; i_TamanoFiltroL = vecs[i].size;
      i_RegistroDestino = vecs[i].dest; i_RegWrite = 1;
      #1;
      chk($sformatf("vec%0d_wb", i), o_DatoEscritura, vecs[i].exp);
      tick();
      i_RegWrite = 0; i_RegDebug = vecs[i].dest;
      #1;
      chk($sformatf("vec%0d_gpr", i), o_DatoDebug, vecs[i].exp);
    end
    chk("vec_cnt", o_ContadorWB, 32'd12);

    // R0 discard and same-cycle bypass on both read ports.
    idle();
    i_ALU = 5; i_RegistroDestino = 0; i_RegWrite = 1; i_RegLectura1 = 0;
    tick();
    i_RegWrite = 0; #1;
    chk("r0_read", o_DatoLeido1, 32'h0);
    chk("r0_cnt", o_ContadorWB, 32'd12);
    i_ALU = 9; i_RegistroDestino = 7; i_RegWrite = 1;
    i_RegLectura1 = 7; i_RegLectura2 = 7; i_RegDebug = 7; #1;
    chk("byp_a", o_DatoLeido1, 32'd9);
    chk("byp_b", o_DatoLeido2, 32'd9);
    chk("byp_dbg", o_DatoDebug, 32'd9);
    tick();
    i_RegWrite = 0; i_ALU = 0; #1;
    chk("byp_after", o_DatoLeido1, 32'd9);

    // Counter: 3 valid, 1 disabled, 1 to R0.
    do_reset();
    chk("cnt_reset", o_ContadorWB, 32'h0);
    for (int i = 0; i < 5; i++) begin
      i_ALU = 32'h100 + i;
      i_RegistroDestino = (i == 4) ? 5'd0 : 5'(i + 1);
      i_RegWrite = (i != 3);
      tick();
    end
    i_RegWrite = 0; #1;
    chk("cnt_three", o_ContadorWB, 32'd3);
    // Reset asserted while a write is presented: write lost.
    i_ALU = 32'hDEAD; i_RegistroDestino = 5; i_RegWrite = 1; i_reset = 0;
    tick();
    i_reset = 1; i_RegWrite = 0; i_RegDebug = 5; #1;
    chk("rst_mid_cnt", o_ContadorWB, 32'h0);
    chk("rst_mid_gpr", o_DatoDebug, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      i_PC8 = $urandom; i_ALU = $urandom; i_DatoMemoria = $urandom; i_Extension = $urandom;
      i_MemToReg = 1'($urandom); i_LUI = ($urandom_range(0, 3) == 0);
      i_JAL = ($urandom_range(0, 3) == 0); i_ZeroExtend = 1'($urandom);
      i_TamanoFiltroL = 2'($urandom); i_RegWrite = ($urandom_range(0, 3) != 0);
      i_RegistroDestino = 5'($urandom);
      i_RegLectura1 = ($urandom_range(0, 3) == 0) ? i_RegistroDestino : 5'($urandom);
      i_RegLectura2 = ($urandom_range(0, 3) == 0) ? i_RegistroDestino : 5'($urandom);
      i_RegDebug = 5'($urandom);
      #1;
      chk("rnd_wb", o_DatoEscritura, m_wb());
      chk("rnd_a", o_DatoLeido1, m_rd(i_RegLectura1));
      chk("rnd_b", o_DatoLeido2, m_rd(i_RegLectura2));
      chk("rnd_dbg", o_DatoDebug, m_rd(i_RegDebug));
      tick();
      chk("rnd_cnt", o_ContadorWB, m_cnt);
    end

    // Reset after random writes clears every register.
    i_RegWrite = 1; i_RegistroDestino = 3;
    do_reset();
    i_RegWrite = 0;
    chk("final_rst_cnt", o_ContadorWB, 32'h0);
    for (int r = 0; r < 32; r++) begin
      i_RegDebug = 5'(r); #1;
      chk($sformatf("final_rst_gpr%0d", r), o_DatoDebug, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
